trace_checker: RTL and testbench
================================

TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter EXP_AW, default 12, width of the expected-trace address (max 4096 records).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, commit FIFO entries (power of two).
REQ-003 SHALL have ports clk  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have ports rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port commit_valid  in  1  a retired-instruction commit event this cycle.
REQ-006 SHALL have ports c_pc/c_regval/c_addr/c_memval  in  16 each  PC, WriteData, MemAddress, MemData of the commit.
REQ-007 SHALL have ports c_regwrite, c_memread, c_memwrite, c_halt  in  1 each; c_reg  in  3  WriteRegister.
REQ-008 SHALL have port exp_rd  out  1  read strobe to expected-trace memory; exp_addr  out  EXP_AW  record index.
REQ-009 SHALL have port exp_data  in  70  {kind[2:0], pc, reg[2:0], regval, addr, memval}; valid the cycle after exp_rd and stable until the next exp_rd.
REQ-010 SHALL have outputs done 1, pass 1, error 1, inst_count 16, mismatch_inum 16, mismatch_field 6 (bits: kind, pc, reg, regval, addr, memval).

Function
REQ-011 SHALL classify each commit: halt->HALT(5); regwrite&memwrite->STU(2); regwrite&memread->LD(1); regwrite->REG(0); memwrite->ST(3); else NOP(4). Halt takes priority.
REQ-012 SHALL push each commit_valid event (class plus fields) into the commit FIFO in the same cycle.
REQ-013 SHALL use FSM states IDLE, PREFETCH, RUN, DONE, ERROR.
REQ-014 SHALL leave IDLE one cycle after reset release, issue exp_rd with exp_addr=0 in PREFETCH, then enter RUN.
REQ-015 SHALL, in RUN with FIFO non-empty, compare head against exp_data, pop, increment inst_count, and issue exp_rd for inst_count+1 in the same cycle; throughput 1 record/cycle.
REQ-016 SHALL compare fields by kind: always kind and pc; REG/LD/STU reg and regval; LD/STU/ST addr; STU/ST memval; NOP/HALT nothing further.
REQ-017 SHALL, on any field mismatch, set mismatch_field bits, mismatch_inum=current inst_count, error=1, enter ERROR; no further pops or reads.
REQ-018 SHALL, on a matching HALT record, enter DONE with done=1, pass=1; inst_count includes the halt.
REQ-019 SHALL treat a FIFO push when full (no simultaneous pop) as overflow: error=1, mismatch_field=6'b111111, enter ERROR.
REQ-020 SHALL allow simultaneous push and pop when full without overflow.
REQ-021 SHALL treat exp_addr reaching 2^EXP_AW-1 without HALT as error with mismatch_field=0, entering ERROR.
REQ-022 SHALL hold DONE and ERROR until reset; commits arriving there are ignored.
REQ-023 SHALL keep exp_rd low outside PREFETCH and RUN pops.
REQ-024 SHALL drive all outputs from registers except exp_rd and exp_addr.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear FSM to IDLE, the FIFO to empty, inst_count, mismatch_inum, mismatch_field, done, pass, error, exp_addr to 0, and exp_rd to 0.
REQ-026 SHALL, on reset mid-run, discard all in-flight commits and restart from record 0.

Structure
REQ-027 SHALL place kind encodings, field-bit indices, the record width (70), and FSM state encodings in shared package trace_pkg.
REQ-028 SHALL implement the FIFO as sub-module commit_fifo (depth FIFO_DEPTH, full/empty flags, wrap-around pointers).

Verification
REQ-029 SHALL test a 3-record trace REG(pc 0x0000, r1=0x0005), ST(pc 0x0002, addr 0x0010, val 0x0005), HALT(pc 0x0004) with matching commits -> done=1, pass=1, inst_count=3.
REQ-030 SHALL test an LD commit with regval 0x1234 against expected 0x1235 at record 4 -> error=1, mismatch_inum=4, mismatch_field=6'b000100.
REQ-031 SHALL test an expected STU against a committed LD -> mismatch_field bit kind set, error=1.
REQ-032 SHALL test 6 back-to-back commits starting in the reset-release cycle -> no overflow; all compared in order.
REQ-033 SHALL test 5 commits pushed while memory is held stalled (test hook) -> overflow, mismatch_field=6'b111111.
REQ-034 SHALL test rst_n asserted after 2 compared records, then a full trace replayed -> exp_addr restarts at 0, final pass=1.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared encodings, record layout and compare helpers for trace_checker
package trace_pkg;

    localparam int REC_W   = 70;
    localparam int FIELD_W = 6;

    localparam logic [2:0] KIND_REG  = 3'd0;
    localparam logic [2:0] KIND_LD   = 3'd1;
    localparam logic [2:0] KIND_STU  = 3'd2;
    localparam logic [2:0] KIND_ST   = 3'd3;
    localparam logic [2:0] KIND_NOP  = 3'd4;
    localparam logic [2:0] KIND_HALT = 3'd5;

    // mismatch_field bit positions, MSB first: kind, pc, reg, regval, addr, memval
    localparam int F_MEMVAL = 0;
    localparam int F_ADDR   = 1;
    localparam int F_REGVAL = 2;
    localparam int F_REG    = 3;
    localparam int F_PC     = 4;
    localparam int F_KIND   = 5;

    localparam logic [FIELD_W-1:0] FIELD_OVERFLOW = 6'b111111;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [2:0]  rd;
        logic [15:0] regval;
        logic [15:0] addr;
        logic [15:0] memval;
    } trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_RUN      = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERROR    = 3'd4
    } state_e;

    function automatic logic [2:0] classify(input logic halt, input logic regwrite,
                                            input logic memread, input logic memwrite);
        if (halt)                      return KIND_HALT;
        else if (regwrite && memwrite) return KIND_STU;
        else if (regwrite && memread)  return KIND_LD;
        else if (regwrite)             return KIND_REG;
        else if (memwrite)             return KIND_ST;
        else                           return KIND_NOP;
    endfunction

    // Which fields participate is decided by the expected record's kind.
    function automatic logic [FIELD_W-1:0] field_diff(input trace_rec_t got, input trace_rec_t want);
        logic [FIELD_W-1:0] d;
        logic cmp_reg;
        logic cmp_addr;
        logic cmp_mem;
        cmp_reg  = (want.kind == KIND_REG) || (want.kind == KIND_LD) || (want.kind == KIND_STU);
        cmp_addr = (want.kind == KIND_LD) || (want.kind == KIND_STU) || (want.kind == KIND_ST);
        cmp_mem  = (want.kind == KIND_STU) || (want.kind == KIND_ST);
        d           = '0;
        d[F_KIND]   = (got.kind != want.kind);
        d[F_PC]     = (got.pc != want.pc);
        d[F_REG]    = cmp_reg && (got.rd != want.rd);
        d[F_REGVAL] = cmp_reg && (got.regval != want.regval);
        d[F_ADDR]   = cmp_addr && (got.addr != want.addr);
        d[F_MEMVAL] = cmp_mem && (got.memval != want.memval);
        return d;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - commit event FIFO with wrap-around pointers and full/empty flags
module commit_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            if (rd_en) rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares retired-instruction commits against an expected trace memory
module trace_checker
    import trace_pkg::*;
#(
    parameter int EXP_AW     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               commit_valid,
    input  logic [15:0]        c_pc,
    input  logic [15:0]        c_regval,
    input  logic [15:0]        c_addr,
    input  logic [15:0]        c_memval,
    input  logic               c_regwrite,
    input  logic               c_memread,
    input  logic               c_memwrite,
    input  logic               c_halt,
    input  logic [2:0]         c_reg,
    input  logic               exp_stall,
    output logic               exp_rd,
    output logic [EXP_AW-1:0]  exp_addr,
    input  logic [REC_W-1:0]   exp_data,
    output logic               done,
    output logic               pass,
    output logic               error,
    output logic [15:0]        inst_count,
    output logic [15:0]        mismatch_inum,
    output logic [FIELD_W-1:0] mismatch_field
);

    state_e             state_q, state_d;
    logic [15:0]        inst_count_q, inst_count_d;
    logic [15:0]        mismatch_inum_q, mismatch_inum_d;
    logic [FIELD_W-1:0] mismatch_field_q, mismatch_field_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               error_q, error_d;

    trace_rec_t         push_rec;
    trace_rec_t         head_rec;
    trace_rec_t         want_rec;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               overflow;
    logic               last_rec;
    logic [FIELD_W-1:0] diff;

    assign push_rec = {classify(c_halt, c_regwrite, c_memread, c_memwrite),
                       c_pc, c_reg, c_regval, c_addr, c_memval};
    assign want_rec = exp_data;

    // Commits are accepted until a verdict is reached; afterwards they are dropped.
    assign push     = commit_valid &&
                      (state_q == ST_IDLE || state_q == ST_PREFETCH || state_q == ST_RUN);
    assign pop      = (state_q == ST_RUN) && !fifo_empty && !exp_stall;
    assign overflow = push && fifo_full && !pop;
    assign diff     = field_diff(head_rec, want_rec);
    assign last_rec = &inst_count_q[EXP_AW-1:0];

    commit_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_commit_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_rec),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d          = state_q;
        inst_count_d     = inst_count_q;
        mismatch_inum_d  = mismatch_inum_q;
        mismatch_field_d = mismatch_field_q;
        done_d           = done_q;
        pass_d           = pass_q;
        error_d          = error_q;
        exp_rd           = 1'b0;
        exp_addr         = inst_count_q[EXP_AW-1:0];

        case (state_q)
            ST_IDLE: state_d = ST_PREFETCH;
            ST_PREFETCH: begin
                if (!exp_stall) begin
                    exp_rd   = 1'b1;
                    exp_addr = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop) begin
                    if (diff != '0) begin
                        mismatch_field_d = diff;
                        mismatch_inum_d  = inst_count_q;
                        error_d          = 1'b1;
                        state_d          = ST_ERROR;
                    end else if (head_rec.kind == KIND_HALT) begin
                        inst_count_d = inst_count_q + 16'd1;
                        done_d       = 1'b1;
                        pass_d       = 1'b1;
                        state_d      = ST_DONE;
                    end else if (last_rec) begin
                        // The trace memory is exhausted without a HALT record.
                        inst_count_d     = inst_count_q + 16'd1;
                        mismatch_field_d = '0;
                        mismatch_inum_d  = inst_count_q;
                        error_d          = 1'b1;
                        state_d          = ST_ERROR;
                    end else begin
                        inst_count_d = inst_count_q + 16'd1;
                        exp_rd       = 1'b1;
                        exp_addr     = inst_count_q[EXP_AW-1:0] + {{(EXP_AW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: ;
        endcase

        if (overflow) begin
            mismatch_field_d = FIELD_OVERFLOW;
            mismatch_inum_d  = inst_count_q;
            error_d          = 1'b1;
            exp_rd           = 1'b0;
            state_d          = ST_ERROR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            inst_count_q     <= '0;
            mismatch_inum_q  <= '0;
            mismatch_field_q <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            inst_count_q     <= inst_count_d;
            mismatch_inum_q  <= mismatch_inum_d;
            mismatch_field_q <= mismatch_field_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            error_q          <= error_d;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign error          = error_q;
    assign inst_count     = inst_count_q;
    assign mismatch_inum  = mismatch_inum_q;
    assign mismatch_field = mismatch_field_q;

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed table-driven bench for trace_checker
module tb_trace_checker;

    logic        clk;
    logic        rst_n;
    logic        commit_valid;
    logic [15:0] c_pc;
    logic [15:0] c_regval;
    logic [15:0] c_addr;
    logic [15:0] c_memval;
    logic        c_regwrite;
    logic        c_memread;
    logic        c_memwrite;
    logic        c_halt;
    logic [2:0]  c_reg;
    logic        exp_stall;
    logic        exp_rd;
    logic [11:0] exp_addr;
    logic [69:0] exp_data;
    logic        done;
    logic        pass;
    logic        error;
    logic [15:0] inst_count;
    logic [15:0] mismatch_inum;
    logic [5:0]  mismatch_field;

    logic [69:0] exp_mem [4096];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        halt;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [2:0]  rd;
        logic [15:0] pc;
        logic [15:0] regval;
        logic [15:0] addr;
        logic [15:0] memval;
        logic [69:0] rec;
    } vec_t;

    typedef struct packed {
        logic [7:0]  start;
        logic [7:0]  len;
        logic        done;
        logic        pass;
        logic        err;
        logic [15:0] cnt;
        logic [15:0] inum;
        logic [5:0]  field;
        logic [7:0]  reads;
    } scen_t;

    vec_t  vecs [18];
    scen_t scen [5];

    trace_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_valid   (commit_valid),
        .c_pc           (c_pc),
        .c_regval       (c_regval),
        .c_addr         (c_addr),
        .c_memval       (c_memval),
        .c_regwrite     (c_regwrite),
        .c_memread      (c_memread),
        .c_memwrite     (c_memwrite),
        .c_halt         (c_halt),
        .c_reg          (c_reg),
        .exp_stall      (exp_stall),
        .exp_rd         (exp_rd),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .done           (done),
        .pass           (pass),
        .error          (error),
        .inst_count     (inst_count),
        .mismatch_inum  (mismatch_inum),
        .mismatch_field (mismatch_field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-trace memory: data appears the cycle after the read strobe and holds.
    initial exp_data = '0;
    always @(posedge clk) begin
        if (exp_rd) exp_data <= exp_mem[exp_addr];
    end

    function automatic logic [69:0] rec(input logic [2:0] k, input logic [15:0] pc, input logic [2:0] rd,
                                        input logic [15:0] rv, input logic [15:0] a, input logic [15:0] m);
        return {k, pc, rd, rv, a, m};
    endfunction

    function automatic vec_t v(input logic h, input logic rw, input logic mr, input logic mw,
                               input logic [2:0] rd, input logic [15:0] pc, input logic [15:0] rv,
                               input logic [15:0] a, input logic [15:0] m, input logic [69:0] r);
        vec_t t;
        t = {h, rw, mr, mw, rd, pc, rv, a, m, r};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    task automatic drive(input vec_t vv);
        commit_valid = 1'b1;
        c_halt       = vv.halt;
        c_regwrite   = vv.regwrite;
        c_memread    = vv.memread;
        c_memwrite   = vv.memwrite;
        c_reg        = vv.rd;
        c_pc         = vv.pc;
        c_regval     = vv.regval;
        c_addr       = vv.addr;
        c_memval     = vv.memval;
    endtask

    task automatic load_mem(input int start, input int len);
        for (int i = 0; i < 8; i++)
            exp_mem[i] = (i < len) ? vecs[start + i].rec : '0;
    endtask

    task automatic run_scen(input int s);
        scen_t sc;
        int    rd_n;
        int    stray;
        logic  fin;
        sc    = scen[s];
        rd_n  = 0;
        stray = 0;
        fin   = 1'b0;
        rst_n = 1'b0;
        commit_valid = 1'b0;
        exp_stall    = 1'b0;
        load_mem(int'(sc.start), int'(sc.len));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c < int'(sc.len)) drive(vecs[int'(sc.start) + c]);
            else commit_valid = 1'b0;
            #1;
            if (exp_rd) begin
                chk($sformatf("s%0d_rd_addr%0d", s, rd_n), 32'(exp_addr), 32'(rd_n));
                rd_n++;
            end
            @(negedge clk);
            if (done || error) fin = 1'b1;
        end
        chk($sformatf("s%0d_finished", s), 32'(fin), 32'd1);
        // Commits offered after the verdict must change nothing.
        for (int k = 0; k < 6; k++) begin
            drive(vecs[14]);
            #1;
            if (exp_rd) stray++;
            @(negedge clk);
        end
        commit_valid = 1'b0;
        chk($sformatf("s%0d_reads_after_end", s), 32'(stray), 32'd0);
        chk($sformatf("s%0d_reads", s), 32'(rd_n), 32'(sc.reads));
        chk($sformatf("s%0d_done", s), 32'(done), 32'(sc.done));
        chk($sformatf("s%0d_pass", s), 32'(pass), 32'(sc.pass));
        chk($sformatf("s%0d_error", s), 32'(error), 32'(sc.err));
        chk($sformatf("s%0d_inst_count", s), 32'(inst_count), 32'(sc.cnt));
        chk($sformatf("s%0d_mismatch_inum", s), 32'(mismatch_inum), 32'(sc.inum));
        chk($sformatf("s%0d_mismatch_field", s), 32'(mismatch_field), 32'(sc.field));
    endtask

    initial begin
        int   rd_seen;
        logic reached;

        // 0..2: REG/ST/HALT trace
        vecs[0]  = v(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 16'h0005, 16'h0000, 16'h0000,
                     rec(3'd0, 16'h0000, 3'd1, 16'h0005, 16'h0000, 16'h0000));
        vecs[1]  = v(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0002, 16'h0000, 16'h0010, 16'h0005,
                     rec(3'd3, 16'h0002, 3'd0, 16'h0000, 16'h0010, 16'h0005));
        vecs[2]  = v(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0004, 16'h0000, 16'h0000, 16'h0000,
                     rec(3'd5, 16'h0004, 3'd0, 16'h0000, 16'h0000, 16'h0000));
        // 3..8: LD regval mismatch at record 4
        vecs[3]  = v(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000, 16'h0011, 16'h0000, 16'h0000,
                     rec(3'd0, 16'h0000, 3'd2, 16'h0011, 16'h0000, 16'h0000));
        vecs[4]  = v(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0002, 16'h0000, 16'h0000, 16'h0000,
                     rec(3'd4, 16'h0002, 3'd0, 16'h0000, 16'h0000, 16'h0000));
        vecs[5]  = v(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0004, 16'h0022, 16'h0030, 16'h0022,
                     rec(3'd2, 16'h0004, 3'd3, 16'h0022, 16'h0030, 16'h0022));
        vecs[6]  = v(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0006, 16'h0000, 16'h0040, 16'h0099,
                     rec(3'd3, 16'h0006, 3'd0, 16'h0000, 16'h0040, 16'h0099));
        vecs[7]  = v(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0008, 16'h1234, 16'h0050, 16'h1234,
                     rec(3'd1, 16'h0008, 3'd4, 16'h1235, 16'h0050, 16'h1234));
        vecs[8]  = v(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h000A, 16'h0000, 16'h0000, 16'h0000,
                     rec(3'd5, 16'h000A, 3'd0, 16'h0000, 16'h0000, 16'h0000));
        // 9: committed LD against expected STU
        vecs[9]  = v(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 16'h0007, 16'h0020, 16'h0007,
                     rec(3'd2, 16'h0000, 3'd1, 16'h0007, 16'h0020, 16'h0007));
        // 10..15: six kinds back to back; unchecked fields deliberately differ
        vecs[10] = v(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 16'h0100, 16'hFFFF, 16'h0000, 16'h0000,
                     rec(3'd0, 16'h0100, 3'd7, 16'hFFFF, 16'h0000, 16'h0000));
        vecs[11] = v(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0102, 16'hABCD, 16'hFFFE, 16'hABCD,
                     rec(3'd1, 16'h0102, 3'd0, 16'hABCD, 16'hFFFE, 16'h0000));
        vecs[12] = v(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0104, 16'h1111, 16'h0008, 16'h5A5A,
                     rec(3'd3, 16'h0104, 3'd0, 16'h0000, 16'h0008, 16'h5A5A));
        vecs[13] = v(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0106, 16'h0001, 16'h0002, 16'h0001,
                     rec(3'd2, 16'h0106, 3'd5, 16'h0001, 16'h0002, 16'h0001));
        vecs[14] = v(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0108, 16'h0000, 16'h0099, 16'h0000,
                     rec(3'd4, 16'h0108, 3'd0, 16'h0000, 16'h0000, 16'h0000));
        vecs[15] = v(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h010A, 16'h0077, 16'h0000, 16'h0000,
                     rec(3'd5, 16'h010A, 3'd0, 16'h0000, 16'h0000, 16'h0000));
        // 16..17: pc and regval both wrong at record 1
        vecs[16] = v(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 16'h0001, 16'h0000, 16'h0000,
                     rec(3'd0, 16'h0000, 3'd1, 16'h0001, 16'h0000, 16'h0000));
        vecs[17] = v(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0004, 16'h0002, 16'h0000, 16'h0000,
                     rec(3'd0, 16'h0002, 3'd1, 16'h0003, 16'h0000, 16'h0000));

        //           start  len  done  pass  err   cnt     inum    field       reads
        scen[0] = {8'd0,  8'd3, 1'b1, 1'b1, 1'b0, 16'd3, 16'd0, 6'b000000, 8'd3};
        scen[1] = {8'd3,  8'd6, 1'b0, 1'b0, 1'b1, 16'd4, 16'd4, 6'b000100, 8'd5};
        scen[2] = {8'd9,  8'd1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 6'b100000, 8'd1};
        scen[3] = {8'd10, 8'd6, 1'b1, 1'b1, 1'b0, 16'd6, 16'd0, 6'b000000, 8'd6};
        scen[4] = {8'd16, 8'd2, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 6'b010100, 8'd2};

        rst_n = 1'b0;
        commit_valid = 1'b0;
        exp_stall = 1'b0;
        c_pc = '0; c_regval = '0; c_addr = '0; c_memval = '0;
        c_regwrite = 1'b0; c_memread = 1'b0; c_memwrite = 1'b0; c_halt = 1'b0; c_reg = '0;
        @(negedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_inst_count", 32'(inst_count), 32'd0);
        chk("rst_mismatch_inum", 32'(mismatch_inum), 32'd0);
        chk("rst_mismatch_field", 32'(mismatch_field), 32'd0);
        chk("rst_exp_rd", 32'(exp_rd), 32'd0);
        chk("rst_exp_addr", 32'(exp_addr), 32'd0);

        for (int s = 0; s < 5; s++) run_scen(s);

        // Memory stalled: four commits fill the FIFO, the fifth overflows.
        rst_n = 1'b0;
        commit_valid = 1'b0;
        exp_stall = 1'b1;
        rd_seen = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(vecs[14]);
            #1;
            if (exp_rd) rd_seen++;
            @(negedge clk);
            if (c == 3) chk("ovf_full_not_error", 32'(error), 32'd0);
        end
        commit_valid = 1'b0;
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_field", 32'(mismatch_field), 32'h3F);
        chk("ovf_done", 32'(done), 32'd0);
        exp_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (exp_rd) rd_seen++;
            @(negedge clk);
        end
        chk("ovf_no_reads", 32'(rd_seen), 32'd0);
        chk("ovf_error_held", 32'(error), 32'd1);
        chk("ovf_inst_count", 32'(inst_count), 32'd0);

        // Reset after two compared records, then replay the whole trace.
        rst_n = 1'b0;
        commit_valid = 1'b0;
        load_mem(10, 6);
        reached = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20 && !reached; c++) begin
            if (c < 4) drive(vecs[10 + c]);
            else commit_valid = 1'b0;
            @(negedge clk);
            if (inst_count == 16'd2) reached = 1'b1;
        end
        chk("mid_reached_two", 32'(reached), 32'd1);
        commit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_async_inst_count", 32'(inst_count), 32'd0);
        chk("mid_async_exp_rd", 32'(exp_rd), 32'd0);
        chk("mid_async_exp_addr", 32'(exp_addr), 32'd0);
        run_scen(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
